trng_markov_extractor: RTL and testbench

- Post-processor for a raw entropy source.
- Samples one raw bit per clock on `latch_bit`.
- Removes bias and first-order (Markov) correlation with a context-split von Neumann extractor: separate pair extractors for "previous raw bit = 0" and "previous raw bit = 1".
- Emits unbiased bits as single-cycle `out_valid` strobes to the downstream consumer.

---
 rtl/trng_markov_extractor.sv | 84 ++++++++
 tb/tb_trng_markov_extractor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_markov_extractor.sv
// rtl/trng_markov_extractor.sv - context-split von Neumann post-processor for a raw entropy bit
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_markov_extractor #(
  parameter int REP_CUTOFF = 32,
  parameter int REP_CNT_W  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic latch_bit,
  output logic out_valid,
  output logic out
);

  logic       prev_bit;
  logic       prev_vld;
  logic [1:0] half;
  logic [1:0] half_vld;
  logic       blocked;

`ifdef TRNG_HEALTH_EN
  logic [REP_CNT_W-1:0] rep_cnt;
  logic [REP_CNT_W-1:0] rep_next;
  logic                 fail;
  logic                 fail_set;

  // Next run length of identical raw bits; restarts at 1 on a change or the first sample.
  always_comb begin
    rep_next = REP_CNT_W'(1);
    if (prev_vld && (latch_bit == prev_bit)) begin
      rep_next = (&rep_cnt) ? rep_cnt : rep_cnt + REP_CNT_W'(1);
    end
    fail_set = (int'(rep_next) >= REP_CUTOFF);
    blocked  = fail | fail_set;
  end

  // Run-length counter and sticky fail flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt <= REP_CNT_W'(1);
      fail    <= 1'b0;
    end else begin
      rep_cnt <= rep_next;
      if (fail_set) begin
        fail <= 1'b1;
      end
    end
  end
`else
  assign blocked = 1'b0;
`endif

  // Context tracking, per-context pair collection and the registered output strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_bit  <= 1'b0;
      prev_vld  <= 1'b0;
      half      <= 2'b00;
      half_vld  <= 2'b00;
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      prev_bit  <= latch_bit;
      prev_vld  <= 1'b1;
      if (blocked) begin
        // A failed source must not leave half-built pairs behind.
        half_vld <= 2'b00;
      end else if (prev_vld) begin
        if (!half_vld[prev_bit]) begin
          half[prev_bit]     <= latch_bit;
          half_vld[prev_bit] <= 1'b1;
        end else begin
          half_vld[prev_bit] <= 1'b0;
          // Pair 10 yields 1, pair 01 yields 0; equal pairs are dropped.
          if (half[prev_bit] != latch_bit) begin
            out       <= half[prev_bit];
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_markov_extractor.sv
// tb/tb_trng_markov_extractor.sv - self-checking bench for trng_markov_extractor
module tb_trng_markov_extractor;

  logic clk = 1'b0;
  logic reset;
  logic latch_bit;
  logic out_valid;
  logic out;

  int n_checks = 0;
  int n_fail   = 0;

  trng_markov_extractor #(.REP_CUTOFF(32), .REP_CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .latch_bit (latch_bit),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic b;
    logic ev;
    logic eo;
  } vec_t;

  vec_t vt[$];

  // Golden model state: raw samples queued per context in arrival order.
  logic mq0[$];
  logic mq1[$];
  logic m_prev;
  logic m_pv;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs away from the edge, let one rising edge pass, then settle.
  task automatic step(input logic r, input logic b);
    reset     = r;
    latch_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_prev = 1'b0;
    m_pv   = 1'b0;
  endtask

  task automatic model_sample(input logic b, output logic ev, output logic eo);
    logic a;
    logic c;
    ev = 1'b0;
    eo = 1'b0;
    if (!m_pv) begin
      m_pv = 1'b1;
    end else if (m_prev == 1'b0) begin
      mq0.push_back(b);
      if (mq0.size() == 2) begin
        a = mq0.pop_front();
        c = mq0.pop_front();
        if (a != c) begin
          ev = 1'b1;
          eo = a;
        end
      end
    end else begin
      mq1.push_back(b);
      if (mq1.size() == 2) begin
        a = mq1.pop_front();
        c = mq1.pop_front();
        if (a != c) begin
          ev = 1'b1;
          eo = a;
        end
      end
    end
    m_prev = b;
  endtask

  initial begin
    int strobes;
    int mism;
    int ones;
    int total;
    int diff;
    logic [31:0] lfsr;
    logic b;
    logic ev;
    logic eo;

    reset     = 1'b0;
    latch_bit = 1'b0;

    // Reset x2, then 0,0,1 -> strobe 0, then quiet cycle.
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    // 0,1,1,0 -> strobe 1 on edge 4; then 1 discards context-0 pair 1,1, out holds.
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1});
    // 0,0, reset, 1,1,0 -> stale half dropped, strobe 1 on third post-reset sample.
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1});
    // Interleaved contexts: 1,0,1,1,0,0 -> strobe 0 (ctx1 0,1) then strobe 1 (ctx0 1,0).
    vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst_n, vt[i].b);
      check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vt[i].ev));
      check($sformatf("vec%0d_out", i), int'(out), int'(vt[i].eo));
    end

    // Strictly alternating stream never yields output.
    step(1'b0, 1'b0);
    strobes = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'(i % 2));
      if (out_valid) strobes++;
    end
    check("alternating_strobes", strobes, 0);

`ifndef TRNG_HEALTH_EN
    // Constant stream never yields output.
    step(1'b0, 1'b0);
    strobes = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b1);
      if (out_valid) strobes++;
    end
    check("constant_strobes", strobes, 0);
`endif

    // Long pseudo-random stream against the queue-based model.
    step(1'b0, 1'b0);
    model_reset();
    lfsr    = 32'hACE1_2468;
    strobes = 0;
    total   = 0;
    ones    = 0;
    mism    = 0;
    for (int i = 0; i < 60000; i++) begin
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      b = lfsr[0];
      step(1'b1, b);
      model_sample(b, ev, eo);
      if (ev) begin
        total++;
        if (eo) ones++;
      end
      if (out_valid) strobes++;
      if ((out_valid != ev) || (ev && (out != eo))) mism++;
    end
    check("lfsr_strobe_count", strobes, total);
    check("lfsr_cycle_mismatches", mism, 0);
    diff = (2 * ones > total) ? (2 * ones - total) : (total - 2 * ones);
    check("lfsr_ones_ratio_within_1pct", int'(50 * diff <= total), 1);

`ifdef TRNG_HEALTH_EN
    // 32 identical bits trip the health test; output stays off until reset.
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
    strobes = 0;
    for (int i = 0; i < 500; i++) begin
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      step(1'b1, lfsr[0]);
      if (out_valid) strobes++;
    end
    check("health_fail_strobes", strobes, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("health_resume_valid", int'(out_valid), 1);
    check("health_resume_out", int'(out), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
